// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests with
// credit-based flow control, and buffers responses for decode with PC+1 tags.
module fetch_queue #(
    parameter logic [29:0] RESET_PC = 30'h100000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [29:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [29:0] inst_pc_plus4,
    input  logic        redirect,
    input  logic [29:0] redirect_target
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready in the same cycle.

    logic [29:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [31:0]   last_inst_q, last_inst_d;
    logic [29:0]   last_pc4_q, last_pc4_d;

    logic [29:0] tag_mem  [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [29:0] pc4_mem  [DEPTH];

    logic [CW:0] credit_used;
    logic        accept;
    logic        resp_keep;
    logic        pop;

    assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    assign imem_req_valid = reset & (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid & imem_req_ready;
    // A response is kept only if it is not stale and no squash is happening now.
    assign resp_keep      = imem_resp_valid & (drop_q == '0) & ~redirect;
    assign inst_valid     = (fifo_cnt_q != '0);
    assign pop            = inst_valid & inst_ready;
    assign inst           = inst_valid ? data_mem[fifo_rd_q] : last_inst_q;
    assign inst_pc_plus4  = inst_valid ? pc4_mem[fifo_rd_q] : last_pc4_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        last_inst_d   = last_inst_q;
        last_pc4_d    = last_pc4_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_resp_valid);
        fifo_cnt_d    = fifo_cnt_q + CW'(resp_keep) - CW'(pop);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 30'd1;
            tag_wr_d   = tag_wr_q + 1'b1;
        end
        if (imem_resp_valid) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end
        if (resp_keep) begin
            fifo_wr_d = fifo_wr_q + 1'b1;
        end
        if (pop) begin
            fifo_rd_d   = fifo_rd_q + 1'b1;
            last_inst_d = data_mem[fifo_rd_q];
            last_pc4_d  = pc4_mem[fifo_rd_q];
        end

        // Every request still in flight after this edge belongs to the old path.
        if (redirect) begin
            fetch_pc_d = redirect_target;
            drop_d     = outstanding_d;
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
        end else if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            fifo_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            last_inst_q   <= '0;
            last_pc4_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            last_inst_q   <= last_inst_d;
            last_pc4_q    <= last_pc4_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            data_mem[fifo_wr_q] <= imem_resp_data;
            pc4_mem[fifo_wr_q]  <= tag_mem[tag_rd_q] + 30'd1;
        end
        if (reset) begin
            assert (!(resp_keep && (fifo_cnt_q == DEPTH_C)));
            assert (!(imem_resp_valid && (outstanding_q == '0)));
            assert (drop_q <= outstanding_q);
            assert (credit_used <= DEPTH_W);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a bench-side memory with random latency and an
// epoch-based model of which fetched instructions must reach decode.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [29:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [29:0] inst_pc_plus4;
    logic        redirect;
    logic [29:0] redirect_target;

    fetch_queue #(.RESET_PC(30'h100000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc_plus4   (inst_pc_plus4),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int epoch  = 0;

    logic [61:0] exp_q[$];       // {inst, pc_plus4} the decode side must see
    logic [29:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          mem_ep_q[$];
    logic [29:0] acc_log[$];
    logic [29:0] del_log[$];
    logic [29:0] model_pc;
    logic [31:0] last_inst;
    logic [29:0] last_pc4;

    function automatic logic [31:0] data_of(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        mem_ep_q.delete();
        model_pc  = 30'h100000;
        last_inst = '0;
        last_pc4  = '0;
        epoch++;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit rr, input bit ir, input bit redir,
                        input logic [29:0] tgt, input int lat);
        bit          resp;
        bit          exp_rv;
        bit          acc;
        logic [61:0] f;
        logic [29:0] a;
        int          e;
        imem_req_ready  = rr;
        inst_ready      = ir;
        redirect        = redir;
        redirect_target = tgt;
        resp = (mem_due_q.size() != 0) && (mem_due_q[0] <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? data_of(mem_addr_q[0]) : $urandom;
        #1;
        exp_rv = (mem_addr_q.size() + exp_q.size()) < 2;
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
        chk("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            chk("inst", 64'(inst), 64'(f[61:30]));
            chk("pc_plus4", 64'(inst_pc_plus4), 64'(f[29:0]));
        end else begin
            chk("inst_hold", 64'(inst), 64'(last_inst));
            chk("pc4_hold", 64'(inst_pc_plus4), 64'(last_pc4));
        end
        acc = imem_req_valid && rr;
        if (acc) acc_log.push_back(imem_req_addr);
        if (inst_valid && ir) del_log.push_back(inst_pc_plus4);
        if (exp_q.size() != 0 && ir) begin
            f = exp_q.pop_front();
            last_inst = f[61:30];
            last_pc4  = f[29:0];
        end
        if (resp) begin
            a = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
            e = mem_ep_q.pop_front();
            if (e == epoch && !redir) exp_q.push_back({data_of(a), a + 30'd1});
        end
        if (acc) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + lat);
            mem_ep_q.push_back(epoch);
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            model_pc = tgt;
        end else if (acc) begin
            model_pc = model_pc + 30'd1;
        end
        chk("credit_inv", 64'((mem_addr_q.size() + exp_q.size()) <= 2), 64'(1));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((mem_addr_q.size() + exp_q.size()) != 0 && n < 50) begin
            step(1'b0, 1'b1, 1'b0, '0, 1);
            n++;
        end
        chk("drain_done", 64'(mem_addr_q.size() + exp_q.size()), 64'(0));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;
        bit in_range;
        int n0;
        reset = 1'b1;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        inst_ready = 0; redirect = 0; redirect_target = '0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("rst_inst_valid", 64'(inst_valid), 64'(0));
        chk("rst_inst", 64'(inst), 64'(0));
        chk("rst_pc4", 64'(inst_pc_plus4), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Streaming with ready memory and 1-cycle latency.
        acc_log.delete(); del_log.delete();
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1);
        chk("t1_addr0", 64'(acc_log[0]), 64'(30'h100000));
        chk("t1_addr1", 64'(acc_log[1]), 64'(30'h100001));
        chk("t1_addr2", 64'(acc_log[2]), 64'(30'h100002));
        chk("t1_pc4_0", 64'(del_log[0]), 64'(30'h100001));
        chk("t1_pc4_1", 64'(del_log[1]), 64'(30'h100002));
        chk("t1_pc4_2", 64'(del_log[2]), 64'(30'h100003));

        // Decode stalled: exactly two requests, then credit exhausted.
        drain();
        acc_log.delete(); del_log.delete();
        repeat (8) step(1'b1, 1'b0, 1'b0, '0, 1);
        chk("t2_req_count", 64'(acc_log.size()), 64'(2));
        chk("t2_no_req", 64'(imem_req_valid), 64'(0));
        chk("t2_head_valid", 64'(inst_valid), 64'(1));
        repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1);

        // Redirect with two requests in flight at 3-cycle latency.
        drain();
        step(1'b1, 1'b1, 1'b0, '0, 3);
        step(1'b1, 1'b1, 1'b0, '0, 3);
        chk("t3_two_inflight", 64'(mem_addr_q.size()), 64'(2));
        step(1'b1, 1'b1, 1'b1, 30'h200000, 3);
        acc_log.delete(); del_log.delete();
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 3);
        chk("t3_new_addr", 64'(acc_log[0]), 64'(30'h200000));
        chk("t3_first_pc4", 64'(del_log[0]), 64'(30'h200001));

        // Redirect coinciding with a response and a dequeue.
        drain();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (exp_q.size() != 0 && mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
                n0 = del_log.size();
                step(1'b1, 1'b1, 1'b1, 30'h300000, 1);
                found = 1;
                chk("t4_deq_delivered", 64'(del_log.size()), 64'(n0 + 1));
                chk("t4_fifo_empty", 64'(inst_valid), 64'(0));
            end else begin
                step(1'b1, 1'b1, 1'b0, '0, 1);
            end
        end
        chk("t4_found", 64'(found), 64'(1));
        del_log.delete();
        repeat (12) step(1'b1, 1'b1, 1'b0, '0, 1);
        chk("t4_delivered_some", 64'(del_log.size() != 0), 64'(1));
        foreach (del_log[i]) begin
            in_range = (del_log[i] >= 30'h300001) && (del_log[i] <= 30'h300010);
            chk("t4_new_path", 64'(in_range), 64'(1));
        end

        // PC wraps modulo 2^30.
        drain();
        step(1'b0, 1'b1, 1'b1, 30'h3FFFFFFF, 1);
        acc_log.delete();
        repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1);
        chk("wrap_addr0", 64'(acc_log[0]), 64'(30'h3FFFFFFF));
        chk("wrap_addr1", 64'(acc_log[1]), 64'(30'h0));

        // Random memory readiness, latency, stalls and redirects.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), 30'($urandom),
                 int'($urandom_range(1, 4)));
        end

        // Asynchronous reset while a request is pending.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((mem_addr_q.size() + exp_q.size()) < 2) found = 1;
            else step(1'b0, 1'b1, 1'b0, '0, 1);
        end
        chk("t6_req_pending", 64'(found), 64'(1));
        imem_req_ready = 0; imem_resp_valid = 0;
        #2 reset = 1'b0;
        #1;
        chk("t6_req_valid", 64'(imem_req_valid), 64'(0));
        chk("t6_inst_valid", 64'(inst_valid), 64'(0));
        chk("t6_inst", 64'(inst), 64'(0));
        chk("t6_pc4", 64'(inst_pc_plus4), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        acc_log.delete(); del_log.delete();
        repeat (8) step(1'b1, 1'b1, 1'b0, '0, 2);
        chk("t6_restart_addr", 64'(acc_log[0]), 64'(30'h100000));
        chk("t6_restart_pc4", 64'(del_log[0]), 64'(30'h100001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
